random_equiv_checker: RTL



---
 rtl/random_equiv_pkg.sv | 33 +++
 rtl/random_equiv_checker_lfsr.sv | 47 ++++
 rtl/random_equiv_checker.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/random_equiv_pkg.sv
// Shared types and constants for the random equivalence checker.
// Holds the FSM state encoding, Galois LFSR tap masks and the no-error index.
package random_equiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Right-shift Galois masks for maximal-length polynomials.
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [23:0] LFSR_TAPS_24 = 24'hE1_0000;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;

    // Unlisted widths get a simple top+bottom tap: it still cycles
    // through nonzero states, just not maximally.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] t;
        unique case (width)
            16:      t = 32'(LFSR_TAPS_16);
            24:      t = 32'(LFSR_TAPS_24);
            32:      t = LFSR_TAPS_32;
            default: t = (32'h1 << (width - 1)) | 32'h1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/random_equiv_checker_lfsr.sv
// Galois LFSR stimulus source with load, step and enable controls.
// Ports: clk, reset, en_i, load_i (reload seed), step_i (advance), cur_o (low OW bits of current value).
module lfsr_stim_gen
    import random_equiv_pkg::*;
#(
    parameter int           W    = 32,
    parameter int           OW   = 13,
    parameter logic [W-1:0] SEED = W'(32'hACE1_0001)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic          load_i,
    input  logic          step_i,
    output logic [OW-1:0] cur_o
);

    localparam logic [W-1:0] TAPS  = W'(lfsr_taps(W));
    localparam logic [W-1:0] SEED0 = (SEED == '0) ? W'(1) : SEED;

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;
    logic [W-1:0] cur;

    // A load is visible in the same cycle so a launch can use the seed.
    assign cur   = load_i ? SEED0 : lfsr_q;
    assign cur_o = cur[OW-1:0];

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = cur;
            if (step_i) begin
                lfsr_d = {1'b0, cur[W-1:1]} ^ (cur[0] ? TAPS : '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/random_equiv_checker.sv
// Random-vector equivalence checker between a fabric and a reference response bus.
// Ports: clk, reset, start; stim_o to both DUTs; gfpga_i/bench_i/bench_valid_i responses;
// busy_o, done_o, pass_o, nb_error_o, mismatch_flags_o, first_err_idx_o results.
module random_equiv_checker
    import random_equiv_pkg::*;
#(
    parameter int                IN_W        = 13,
    parameter int                OUT_W       = 7,
    parameter int                LFSR_W      = 32,
    parameter logic [LFSR_W-1:0] SEED        = LFSR_W'(32'hACE1_0001),
    parameter int                NUM_VECTORS = 8,
    parameter int                SKIP_CYCLES = 1,
    parameter int                COMPARE_LAT = 1,
    parameter int                ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IN_W-1:0]  stim_o,
    input  logic [OUT_W-1:0] gfpga_i,
    input  logic [OUT_W-1:0] bench_i,
    input  logic [OUT_W-1:0] bench_valid_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] nb_error_o,
    output logic [OUT_W-1:0] mismatch_flags_o,
    output logic [15:0]      first_err_idx_o
);

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP_CYCLES - 1);
    localparam logic [CNT_W-1:0] VEC_LAST  = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(COMPARE_LAT - 1);
    localparam int PC_W  = $clog2(OUT_W + 1);
    localparam int SUM_W = ERR_W + PC_W + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [15:0]            vec_idx_q, vec_idx_d;
    logic [15:0]            launch_idx;
    logic [IN_W-1:0]        stim_q, stim_d;
    logic [IN_W-1:0]        lfsr_cur;
    logic                   start_ok;
    logic                   launch;

    logic [COMPARE_LAT-1:0]       pipe_v_q, pipe_v_d;
    logic [COMPARE_LAT-1:0][15:0] pipe_idx_q, pipe_idx_d;

    logic [ERR_W-1:0]       err_q, err_d, err_sat;
    logic [OUT_W-1:0]       flags_q, flags_d;
    logic [15:0]            first_q, first_d;
    logic [OUT_W-1:0]       miss;
    logic [PC_W-1:0]        pop;
    logic [SUM_W-1:0]       sum;
    logic                   cmp_v;
    logic [15:0]            cmp_idx;

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d = '0;
                    if (SKIP_CYCLES == 0) state_d = ST_RUN;
                    else                  state_d = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (cnt_q == SKIP_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1;
                end
            end
            ST_RUN: begin
                if (cnt_q == VEC_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A vector is launched on every edge that lands in (or stays in) RUN,
    // so vector k is on stim_o throughout RUN cycle k.
    assign launch     = (state_d == ST_RUN);
    assign launch_idx = start_ok ? 16'd0 : vec_idx_q;

    lfsr_stim_gen #(
        .W    (LFSR_W),
        .OW   (IN_W),
        .SEED (SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .en_i   (start_ok | launch),
        .load_i (start_ok),
        .step_i (launch),
        .cur_o  (lfsr_cur)
    );

    always_comb begin
        stim_d    = stim_q;
        vec_idx_d = vec_idx_q;
        if (start_ok) begin
            stim_d    = '0;
            vec_idx_d = '0;
        end
        if (launch) begin
            stim_d    = lfsr_cur;
            vec_idx_d = launch_idx + 16'd1;
        end
    end

    always_comb begin
        pipe_v_d      = pipe_v_q;
        pipe_idx_d    = pipe_idx_q;
        pipe_v_d[0]   = launch;
        pipe_idx_d[0] = launch_idx;
        for (int i = 1; i < COMPARE_LAT; i++) begin
            pipe_v_d[i]   = pipe_v_q[i-1];
            pipe_idx_d[i] = pipe_idx_q[i-1];
        end
    end

    assign cmp_v   = pipe_v_q[COMPARE_LAT-1];
    assign cmp_idx = pipe_idx_q[COMPARE_LAT-1];
    assign miss    = (gfpga_i ^ bench_i) & bench_valid_i;

    always_comb begin
        pop = '0;
        for (int i = 0; i < OUT_W; i++) begin
            pop = pop + PC_W'(miss[i]);
        end
    end

    // Widened sum so the clamp sees the true total instead of a wrapped one.
    assign sum     = SUM_W'(err_q) + SUM_W'(pop);
    assign err_sat = (sum > SUM_W'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];

    always_comb begin
        err_d   = err_q;
        flags_d = flags_q;
        first_d = first_q;
        if (start_ok) begin
            err_d   = '0;
            flags_d = '0;
            first_d = NO_ERR_IDX;
        end else if (cmp_v) begin
            err_d   = err_sat;
            flags_d = flags_q | miss;
            if ((miss != '0) && (first_q == NO_ERR_IDX)) begin
                first_d = cmp_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            vec_idx_q  <= '0;
            stim_q     <= '0;
            pipe_v_q   <= '0;
            pipe_idx_q <= '0;
            err_q      <= '0;
            flags_q    <= '0;
            first_q    <= NO_ERR_IDX;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vec_idx_q  <= vec_idx_d;
            stim_q     <= stim_d;
            pipe_v_q   <= pipe_v_d;
            pipe_idx_q <= pipe_idx_d;
            err_q      <= err_d;
            flags_q    <= flags_d;
            first_q    <= first_d;
        end
    end

    assign stim_o           = stim_q;
    assign busy_o           = (state_q == ST_WARMUP) || (state_q == ST_RUN) ||
                              (state_q == ST_DRAIN);
    assign done_o           = (state_q == ST_DONE);
    assign pass_o           = done_o && (err_q == '0);
    assign nb_error_o       = err_q;
    assign mismatch_flags_o = flags_q;
    assign first_err_idx_o  = first_q;

endmodule
